split_cons_scheduler: RTL

- Sequences evaluation of one constraint split (three constraints over var_140 [3:0] and var_11 [11:0]) for a candidate assignment.
- Uses a single shared evaluator, one constraint per cycle; early abort on first failure is optional.
- Sits between the candidate generator (upstream, valid/ready) and the BDD solver result collector (downstream, valid/ready).
- Keeps saturating pass/fail statistics.

---
 rtl/split_cons_pkg.sv | 29 ++
 rtl/split_cons_eval.sv | 36 +++
 rtl/split_cons_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/split_cons_pkg.sv
`default_nettype none
// ============================================================================
// Module   : split_cons_pkg
// Purpose  : Shared types and constants for the constraint-split scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package split_cons_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   // Constraint indices, in evaluation order
   localparam logic [1:0] C76_IDX  = 2'd0;
   localparam logic [1:0] C99_IDX  = 2'd1;
   localparam logic [1:0] C17_IDX  = 2'd2;
   localparam logic [1:0] NO_FAIL  = 2'd3;
   localparam int         NUM_CONS = 3;

   // Arithmetic constants of the individual constraints
   localparam logic [15:0] C99_OFFSET = 16'hBA9;
   localparam int          C99_SHIFT  = 4;
   localparam logic [3:0]  C17_DIV    = 4'd5;

endpackage
`default_nettype wire

// File: rtl/split_cons_eval.sv
`default_nettype none
// ============================================================================
// Module   : split_cons_eval
// Purpose  : Shared combinational evaluator; returns pass for constraint idx.
// Revision : 1.0 - initial release
// ============================================================================
module split_cons_eval
   import split_cons_pkg::*;
(
   input  logic [1:0]  idx,
   input  logic [3:0]  v140,
   input  logic [11:0] v11,
   output logic        pass
);

   logic [15:0] w_c99_sum;
   logic [15:0] w_c99_shr;
   logic [3:0]  w_c17_neg;
   logic [3:0]  w_c17_quo;

   // Evaluate the constraint selected by idx on the given candidate
   always_comb begin
      w_c99_sum = {4'd0, v11} + C99_OFFSET;
      w_c99_shr = w_c99_sum >> C99_SHIFT;
      w_c17_neg = 4'd0 - v140;
      w_c17_quo = w_c17_neg / C17_DIV;
      case (idx)
         C76_IDX: pass = (v140 != 4'd0) && (v11 != 12'd0);
         C99_IDX: pass = (w_c99_shr != 16'd0);
         C17_IDX: pass = (w_c17_quo != 4'd0);
         default: pass = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/split_cons_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : split_cons_scheduler
// Purpose  : Sequences the three constraints of one split through a shared
//            evaluator, one per cycle, and reports the result downstream.
// Revision : 1.0 - initial release
// ============================================================================
module split_cons_scheduler
   import split_cons_pkg::*;
#(
   parameter bit ABORT_EARLY = 1'b1,
   parameter int CNT_W       = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_v140,
   input  logic [11:0]      in_v11,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_sat,
   output logic [2:0]       res_fail_mask,
   output logic [1:0]       res_first_fail,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   state_t           r_state, w_next_state;
   logic [3:0]       r_v140;
   logic [11:0]      r_v11;
   logic [1:0]       r_idx;
   logic [2:0]       r_mask;
   logic [1:0]       r_first_fail;
   logic             r_res_sat;
   logic [2:0]       r_res_mask;
   logic [1:0]       r_res_first_fail;
   logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;
   logic             w_pass, w_accept, w_last, w_deliver;
   logic [2:0]       w_mask_upd;
   logic [1:0]       w_ff_upd;

   split_cons_eval u_eval (
      .idx  (r_idx),
      .v140 (r_v140),
      .v11  (r_v11),
      .pass (w_pass)
   );

   // Fold the current constraint's outcome into mask and first-fail index
   always_comb begin
      w_mask_upd = r_mask;
      w_ff_upd   = r_first_fail;
      if (!w_pass) begin
         w_mask_upd = r_mask | (3'b001 << r_idx);
         if (r_first_fail == NO_FAIL)
            w_ff_upd = r_idx;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // FSM next-state and handshake outputs
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      res_valid    = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      w_deliver    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = EVAL;
            end
         end
         EVAL: begin
            if ((!w_pass && ABORT_EARLY) || (r_idx == C17_IDX)) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_deliver    = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Candidate capture, per-constraint accumulation and result latching;
   // the result registers only move at EVAL->DONE so they hold elsewhere
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v140           <= 4'd0;
         r_v11            <= 12'd0;
         r_idx            <= C76_IDX;
         r_mask           <= 3'b000;
         r_first_fail     <= NO_FAIL;
         r_res_sat        <= 1'b0;
         r_res_mask       <= 3'b000;
         r_res_first_fail <= NO_FAIL;
      end else if (w_accept) begin
         r_v140       <= in_v140;
         r_v11        <= in_v11;
         r_idx        <= C76_IDX;
         r_mask       <= 3'b000;
         r_first_fail <= NO_FAIL;
      end else if (r_state == EVAL) begin
         r_mask       <= w_mask_upd;
         r_first_fail <= w_ff_upd;
         if (w_last) begin
            r_res_sat        <= (w_mask_upd == 3'b000);
            r_res_mask       <= w_mask_upd;
            r_res_first_fail <= w_ff_upd;
         end else begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // Saturating statistics, bumped once per delivered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
      end else if (w_deliver) begin
         if (r_res_sat) begin
            if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
         end else begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
         end
      end
   end

   assign res_sat        = r_res_sat;
   assign res_fail_mask  = r_res_mask;
   assign res_first_fail = r_res_first_fail;
   assign pass_cnt       = r_pass_cnt;
   assign fail_cnt       = r_fail_cnt;

endmodule
`default_nettype wire
